// File: rtl/aes_key_expander_pkg.sv
// ============================================================================
// Module     : aes_pkg
// Description: Shared types, constants and helpers for the AES-128 key
//              expander. Optional zeroize state under AES_KEY_EXP_ZEROIZE_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NW = 44;
  localparam logic [7:0] RCON_INIT = 8'h01;

`ifdef AES_KEY_EXP_ZEROIZE_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE   = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_LOAD   = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_EXPAND = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_DONE   = STATE_W'(3);
`ifdef AES_KEY_EXP_ZEROIZE_EN
  localparam logic [STATE_W-1:0] ST_ZERO   = STATE_W'(4);
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expander_if.sv
// ============================================================================
// Module     : aes_key_expander_if
// Description: Key stream and round-key read port bundle for the key expander.
//              Adds zeroize when AES_KEY_EXP_ZEROIZE_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_key_expander_if;
  logic         key_valid;
  logic [31:0]  key_data;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         keys_valid;
  logic         busy;
`ifdef AES_KEY_EXP_ZEROIZE_EN
  logic         zeroize;
`endif

  modport master (
    output key_valid, key_data, rk_addr,
    input  key_ready, rk_data, keys_valid, busy
`ifdef AES_KEY_EXP_ZEROIZE_EN
    , output zeroize
`endif
  );

  modport slave (
    input  key_valid, key_data, rk_addr,
    output key_ready, rk_data, keys_valid, busy
`ifdef AES_KEY_EXP_ZEROIZE_EN
    , input zeroize
`endif
  );
endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module     : aes_sbox
// Description: Combinational AES forward S-box, one byte in, one byte out.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

`default_nettype wire

// File: rtl/aes_key_expander.sv
// ============================================================================
// Module     : aes_key_expander
// Description: AES-128 key schedule: loads a key word-by-word, expands it one
//              word per cycle and serves 11 round keys. Optional macro
//              AES_KEY_EXP_ZEROIZE_EN adds a zeroize input and ZERO state.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expander
  import aes_pkg::*;
#(
  parameter int N_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  aes_key_expander_if.slave bus
);

  if (N_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expander: only N_ROUNDS=10 (AES-128) is supported");
  end

  state_t      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [7:0]  rcon_q,  rcon_d;
  logic [31:0] w_q [AES_NW];
  logic [31:0] w_d [AES_NW];

  logic        accept;
  logic [31:0] w_prev, rot, sub, temp;
  logic [5:0]  zbase, rk_base;
  logic [3:0]  rk_sel;

  assign w_prev = w_q[cnt_q - 6'd1];
  assign rot    = rot_word(w_prev);

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot[8*j +: 8]),
      .out_byte (sub[8*j +: 8])
    );
  end

  assign temp  = (cnt_q[1:0] == 2'b00) ? (sub ^ {rcon_q, 24'h0}) : w_prev;
  assign zbase = {cnt_q[3:0], 2'b00};

  // key_ready is also gated by reset so the block never advertises space while held
  assign bus.key_ready  = reset & ((state_q == ST_IDLE) | (state_q == ST_LOAD) |
                                   (state_q == ST_DONE));
  assign bus.keys_valid = (state_q == ST_DONE);
`ifdef AES_KEY_EXP_ZEROIZE_EN
  assign bus.busy       = (state_q == ST_LOAD) | (state_q == ST_EXPAND) |
                          (state_q == ST_ZERO);
`else
  assign bus.busy       = (state_q == ST_LOAD) | (state_q == ST_EXPAND);
`endif
  assign accept = bus.key_valid & bus.key_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
`ifdef AES_KEY_EXP_ZEROIZE_EN
    if (bus.zeroize) begin
      state_d = ST_ZERO;
      cnt_d   = 6'd0;
    end else
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          w_d[0]  = bus.key_data;
          cnt_d   = 6'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          w_d[cnt_q] = bus.key_data;
          if (cnt_q == 6'd3) begin
            cnt_d   = 6'd4;
            rcon_d  = RCON_INIT;
            state_d = ST_EXPAND;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_EXPAND: begin
        w_d[cnt_q] = w_q[cnt_q - 6'd4] ^ temp;
        if (cnt_q[1:0] == 2'b00) rcon_d = xtime(rcon_q);
        if (cnt_q == 6'(AES_NW - 1)) begin
          cnt_d   = 6'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`ifdef AES_KEY_EXP_ZEROIZE_EN
      ST_ZERO: begin
        for (int k = 0; k < AES_NK; k++) w_d[zbase + 6'(k)] = 32'h0;
        if (cnt_q == 6'd10) begin
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      rcon_q  <= 8'h00;
      for (int i = 0; i < AES_NW; i++) w_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      w_q     <= w_d;
    end
  end

  assign rk_sel  = (bus.rk_addr <= 4'd10) ? bus.rk_addr : 4'd0;
  assign rk_base = {rk_sel, 2'b00};

  assign bus.rk_data = (bus.keys_valid && (bus.rk_addr <= 4'd10)) ?
                       {w_q[rk_base], w_q[rk_base + 6'd1],
                        w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]} : 128'h0;

endmodule

`default_nettype wire

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequences AES-128 key expansion and holds the 11 round keys, 128 bits each, used by the AES core array.
- Accepts a 128-bit cipher key as four 32-bit words over a valid/ready stream.
- Expands the key at one 32-bit word per cycle.
- Serves round keys to the core scheduler through a 4-bit address / 128-bit data read port.
- Sits between the host key stream and the scheduler's round_key / round_key_addr interface. It replaces any preloaded key ROM.

Parameters:
- N_ROUNDS, 10, number of AES rounds. Key store depth is N_ROUNDS+1. Only 10 (AES-128) is supported. Any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state.
- key_valid  input  1  key word present on key_data.
- key_data  input  32  key word. The first word accepted is key bits [127:96], the last is [31:0].
- key_ready  output  1  block can accept a key word.
- rk_addr  input  4  round key index, 0..10.
- rk_data  output  128  round key at rk_addr (combinational read).
- keys_valid  output  1  full schedule is present and consistent.
- busy  output  1  a load or expansion is in progress.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; word counter and rcon register clear to 0.
  - All 44 key-store words clear to 0.
  - keys_valid=0, busy=0, key_ready=0 while reset is held.
  - Reset mid-load or mid-expansion abandons the operation; no partial keys remain.
- States: IDLE, LOAD, EXPAND, DONE.
- key_ready:
  - 1 in IDLE, LOAD and DONE.
  - 0 in EXPAND.
  - Combinational from state only, never from key_valid.
- A key word is accepted on any cycle with key_valid & key_ready:
  - It is written to w[cnt] and cnt increments.
  - The first accept from IDLE or DONE resets cnt to 0, writes w[0] and moves to LOAD.
  - In DONE, that first accept drops keys_valid on the following cycle (old schedule invalid).
- LOAD:
  - After the accept that writes w[3], go to EXPAND with cnt=4 and rcon=8'h01.
  - key_valid gaps are allowed; LOAD waits indefinitely.
- EXPAND, one word per cycle, i = cnt:
  - temp = w[i-1].
  - If i%4==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon), i.e. 01,02,04,...,80,1B,36.
  - w[i] <= w[i-4] ^ temp.
  - The edge that writes w[43] moves the FSM to DONE.
- Latency: keys_valid rises exactly 40 cycles after the edge that accepted key word 3.
- keys_valid = (state==DONE). busy = (state==LOAD | state==EXPAND). Both are registered state decodes.
- rk_data:
  - Equals {w[4a], w[4a+1], w[4a+2], w[4a+3]} for a = rk_addr when keys_valid=1 and rk_addr<=10.
  - Otherwise 128'h0, including rk_addr 11..15 and whenever keys_valid=0.
- The input key is retained in w[0..3]; rk_addr=0 returns it.

Optional Feature:
- Macro: AES_KEY_EXP_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit) and state ZERO.
  - A zeroize=1 sample in any state enters ZERO, overriding a simultaneous key accept.
  - ZERO clears one round key (4 words) per cycle, indices 0..10: 11 cycles, then IDLE.
  - During ZERO: key_ready=0, busy=1, keys_valid=0, rk_data=0.
  - A zeroize asserted while already in ZERO restarts the clear at index 0.
- Not defined:
  - Port and state are absent.
  - Key material persists until overwritten by a new key or cleared by reset.

Decomposition:
- Package aes_pkg holds:
  - the state enum (2-bit; 3-bit when AES_KEY_EXP_ZEROIZE_EN is defined),
  - AES_NK=4, AES_NW=44 and RCON_INIT=8'h01,
  - functions xtime and rot_word.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4 times for SubWord.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c streamed back-to-back:
  - keys_valid rises 40 cycles after the 4th accept.
  - rk_addr=1 -> a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk_addr=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - rk_addr=0 -> the input key.
- Same key with random key_valid gaps of 0-5 cycles:
  - Identical round keys.
  - busy high from the first accept until keys_valid rises.
  - key_ready low for all 40 EXPAND cycles.
- In DONE, stream key 000102030405060708090a0b0c0d0e0f:
  - keys_valid falls the cycle after the first accept.
  - Afterwards rk_addr=10 -> 13111d7f e3944a17 f307a78b 4d2b30c5.
- Assert reset low at EXPAND cycle 20:
  - Immediately keys_valid=0, busy=0 and rk_data=0 for every rk_addr.
  - After release a fresh key load completes normally.
- With keys_valid=1, drive rk_addr=11..15 -> rk_data=0. Drive rk_addr=0..10 -> matches the golden model.
- With AES_KEY_EXP_ZEROIZE_EN defined, pulse zeroize in DONE:
  - 11 cycles in ZERO, then IDLE.
  - Every key-store word reads 0 when checked through the bench backdoor.
  - A new key expands correctly afterwards.
